// File: rtl/task_dispatch_sequencer.sv
// Round-robin dispatcher for NCH timed task requests sharing one task resource.
// Captures per-channel Start strobes, grants one task at a time and times it out.
module task_dispatch_sequencer #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned LEN_W = 8,
  localparam int unsigned CH_W = $clog2(NCH)
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [NCH-1:0]     Start,
  input  logic [NCH*LEN_W-1:0] Len,
  input  logic               Enable,
  input  logic               ClrOvf,
  output logic               Busy,
  output logic [NCH-1:0]     Active,
  output logic [LEN_W-1:0]   Count,
  output logic               Done,
  output logic [CH_W-1:0]    DoneCh,
  output logic [NCH-1:0]     Pending,
  output logic [NCH-1:0]     Overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   overflow_q, overflow_d;
  logic [NCH-1:0]   active_q, active_d;
  logic [LEN_W-1:0] len_q [NCH];
  logic [LEN_W-1:0] len_d [NCH];
  logic [LEN_W-1:0] count_q, count_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CH_W-1:0]  cur_q, cur_d;
  logic [CH_W-1:0]  done_ch_q, done_ch_d;
  logic             done_q, done_d;

  logic             grant_found;
  logic [CH_W-1:0]  grant_idx;
  logic             grant_fire;
  int unsigned      scan_idx;

  // First pending channel after the last one granted, wrapping modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      scan_idx = (32'(last_q) + k) % NCH;
      if (!grant_found && pending_q[CH_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(scan_idx);
      end
    end
  end

  assign grant_fire = (state_q == StIdle) && Enable && grant_found;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = ClrOvf ? '0 : overflow_q;
    active_d   = active_q;
    len_d      = len_q;
    count_d    = count_q;
    last_d     = last_q;
    cur_d      = cur_q;
    done_ch_d  = done_ch_q;
    done_d     = 1'b0;

    // A Start on the grant edge refills the slot being consumed instead of overflowing.
    for (int i = 0; i < NCH; i++) begin
      if (grant_fire && (grant_idx == CH_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (Start[i]) begin
        if (!pending_q[i] || (grant_fire && (grant_idx == CH_W'(i)))) begin
          pending_d[i] = 1'b1;
          len_d[i]     = Len[i*LEN_W +: LEN_W];
        end else begin
          overflow_d[i] = 1'b1;
        end
      end
    end

    case (state_q)
      StIdle: begin
        if (grant_fire) begin
          state_d  = StRun;
          last_d   = grant_idx;
          cur_d    = grant_idx;
          active_d = NCH'(1) << grant_idx;
          count_d  = (len_q[grant_idx] == '0) ? '0 : len_q[grant_idx] - LEN_W'(1);
        end
      end
      StRun: begin
        if (count_q != '0) begin
          count_d = count_q - LEN_W'(1);
        end else begin
          state_d   = StDone;
          active_d  = '0;
          done_d    = 1'b1;
          done_ch_d = cur_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      overflow_q <= '0;
      active_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        len_q[i] <= '0;
      end
      count_q    <= '0;
      last_q     <= CH_W'(NCH - 1);
      cur_q      <= '0;
      done_ch_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      active_q   <= active_d;
      len_q      <= len_d;
      count_q    <= count_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      done_ch_q  <= done_ch_d;
      done_q     <= done_d;
    end
  end

  assign Busy     = (state_q == StRun);
  assign Active   = active_q;
  assign Count    = count_q;
  assign Done     = done_q;
  assign DoneCh   = done_ch_q;
  assign Pending  = pending_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_task_dispatch_sequencer.sv
// Directed bench for task_dispatch_sequencer (NCH=4, LEN_W=8): vector table plus
// hand-written sequences for overflow, enable gating, grant-edge refill and async reset.
module tb_task_dispatch_sequencer;

  logic        Clk;
  logic        nReset;
  logic [3:0]  Start;
  logic [31:0] Len;
  logic        Enable;
  logic        ClrOvf;
  logic        Busy;
  logic [3:0]  Active;
  logic [7:0]  Count;
  logic        Done;
  logic [1:0]  DoneCh;
  logic [3:0]  Pending;
  logic [3:0]  Overflow;

  int n_checks = 0;
  int n_errors = 0;

  task_dispatch_sequencer #(
    .NCH   (4),
    .LEN_W (8)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .Start    (Start),
    .Len      (Len),
    .Enable   (Enable),
    .ClrOvf   (ClrOvf),
    .Busy     (Busy),
    .Active   (Active),
    .Count    (Count),
    .Done     (Done),
    .DoneCh   (DoneCh),
    .Pending  (Pending),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rstn;
    logic [3:0]  start;
    logic [31:0] len;
    logic        en;
    logic        clr;
    logic        busy;
    logic [3:0]  act;
    logic [7:0]  cnt;
    logic        done;
    logic [1:0]  ch;
    logic [3:0]  pend;
    logic [3:0]  ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] lens(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(input logic rstn, input logic [3:0] start, input logic [31:0] len,
                              input logic en, input logic clr, input logic busy,
                              input logic [3:0] act, input logic [7:0] cnt, input logic done,
                              input logic [1:0] ch, input logic [3:0] pend,
                              input logic [3:0] ovf);
    vec_t v;
    v.rstn = rstn; v.start = start; v.len = len; v.en = en; v.clr = clr;
    v.busy = busy; v.act = act; v.cnt = cnt; v.done = done; v.ch = ch;
    v.pend = pend; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic eb, input logic [3:0] ea,
                       input logic [7:0] ec, input logic ed, input logic [1:0] ech,
                       input logic [3:0] ep, input logic [3:0] eo);
    n_checks++;
    if ({Busy, Active, Count, Done, DoneCh, Pending, Overflow} !== {eb, ea, ec, ed, ech, ep, eo})
    begin
      n_errors++;
      $display("FAIL %s: got busy=%b act=%b cnt=%0d done=%b ch=%0d pend=%b ovf=%b, want busy=%b act=%b cnt=%0d done=%b ch=%0d pend=%b ovf=%b",
               name, Busy, Active, Count, Done, DoneCh, Pending, Overflow,
               eb, ea, ec, ed, ech, ep, eo);
    end
  endtask

  task automatic sc(input string name, input logic [3:0] st, input logic [31:0] ln,
                    input logic en, input logic clr, input logic eb, input logic [3:0] ea,
                    input logic [7:0] ec, input logic ed, input logic [1:0] ech,
                    input logic [3:0] ep, input logic [3:0] eo);
    @(negedge Clk);
    Start = st; Len = ln; Enable = en; ClrOvf = clr;
    @(posedge Clk);
    #1;
    check(name, eb, ea, ec, ed, ech, ep, eo);
  endtask

  initial begin
    vec_t v;
    nReset = 1'b0; Start = '0; Len = '0; Enable = 1'b0; ClrOvf = 1'b0;

    // Single task, len 3
    vecs.push_back(mk(1, 4'b0001, lens(3,0,0,0), 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0001, 2, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0001, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0001, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0));
    // All four channels at once, then round-robin restart from last=3
    vecs.push_back(mk(1, 4'b1111, lens(1,1,1,1), 1, 0, 0, 4'b0000, 0, 0, 0, 4'b1111, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0001, 0, 0, 0, 4'b1110, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 4'b1110, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b1110, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0010, 0, 0, 0, 4'b1100, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 1, 4'b1100, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 1, 4'b1100, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0100, 0, 0, 1, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 2, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 2, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b1000, 0, 0, 2, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 3, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0101, lens(1,1,1,1), 1, 0, 0, 4'b0000, 0, 0, 3, 4'b0101, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0001, 0, 0, 3, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 2, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 2, 4'b0000, 0));
    // Zero length runs one cycle
    vecs.push_back(mk(1, 4'b1000, lens(0,0,0,0), 1, 0, 0, 4'b0000, 0, 0, 2, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 4'b1000, 0, 0, 2, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 3, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 3, 4'b0000, 0));

    repeat (2) @(posedge Clk);
    #1;
    check("reset", 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge Clk);
      nReset = v.rstn; Start = v.start; Len = v.len; Enable = v.en; ClrOvf = v.clr;
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d", i), v.busy, v.act, v.cnt, v.done, v.ch, v.pend, v.ovf);
    end

    // Overflow on a second Start while pending; stored length stays 5
    sc("ovf_cap",   4'b0010, lens(0,5,0,0), 0, 0, 0, 4'b0000, 0, 0, 3, 4'b0010, 4'b0000);
    sc("ovf_drop",  4'b0010, lens(0,9,0,0), 0, 0, 0, 4'b0000, 0, 0, 3, 4'b0010, 4'b0010);
    sc("ovf_grant", 4'b0000, 0, 1, 0, 1, 4'b0010, 4, 0, 3, 4'b0000, 4'b0010);
    for (int c = 3; c >= 0; c--) begin
      sc($sformatf("ovf_run%0d", c), 4'b0000, 0, 1, 0, 1, 4'b0010, 8'(c), 0, 3, 4'b0000, 4'b0010);
    end
    sc("ovf_done",  4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 1, 4'b0000, 4'b0010);
    sc("ovf_clr",   4'b0000, 0, 1, 1, 0, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000);

    // Enable low holds the request without granting
    sc("en_cap", 4'b0100, lens(0,0,2,0), 0, 0, 0, 4'b0000, 0, 0, 1, 4'b0100, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      sc($sformatf("en_hold%0d", c), 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 4'b0100, 4'b0000);
    end
    sc("en_grant", 4'b0000, 0, 1, 0, 1, 4'b0100, 1, 0, 1, 4'b0000, 4'b0000);
    sc("en_run",   4'b0000, 0, 1, 0, 1, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000);
    sc("en_done",  4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 2, 4'b0000, 4'b0000);
    sc("en_idle",  4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 2, 4'b0000, 4'b0000);

    // Overflow set beats a simultaneous clear
    sc("sw_cap", 4'b0001, lens(2,0,0,0), 0, 0, 0, 4'b0000, 0, 0, 2, 4'b0001, 4'b0000);
    sc("sw_set", 4'b0001, lens(7,0,0,0), 0, 1, 0, 4'b0000, 0, 0, 2, 4'b0001, 4'b0001);
    sc("sw_clr", 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, 2, 4'b0001, 4'b0000);

    // Start on the grant edge: old length runs, new request stays pending
    sc("ge_grant",   4'b0001, lens(7,0,0,0), 1, 0, 1, 4'b0001, 1, 0, 2, 4'b0001, 4'b0000);
    sc("ge_run",     4'b0000, 0, 1, 0, 1, 4'b0001, 0, 0, 2, 4'b0001, 4'b0000);
    sc("ge_done",    4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 4'b0001, 4'b0000);
    sc("ge_idle",    4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000);
    sc("ge_regrant", 4'b0000, 0, 1, 0, 1, 4'b0001, 6, 0, 0, 4'b0000, 4'b0000);
    sc("ge_run5",    4'b0000, 0, 1, 0, 1, 4'b0001, 5, 0, 0, 4'b0000, 4'b0000);
    sc("ge_run4",    4'b0000, 0, 1, 0, 1, 4'b0001, 4, 0, 0, 4'b0000, 4'b0000);

    // Asynchronous reset mid-task
    #2;
    nReset = 1'b0;
    #1;
    check("rst_async", 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    @(posedge Clk);
    #1;
    check("rst_held", 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    @(negedge Clk);
    nReset = 1'b1;
    sc("rst_idle",  4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    sc("rst_cap",   4'b1101, lens(1,1,1,1), 1, 0, 0, 4'b0000, 0, 0, 0, 4'b1101, 4'b0000);
    sc("rst_grant", 4'b0000, 0, 1, 0, 1, 4'b0001, 0, 0, 0, 4'b1100, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
